score_fill_ctrl: RTL and testbench

Sequencer that drives the score RAM manager to fill the (N+1)x(N+1) Needleman-Wunsch score matrix. It is the initiator on the manager's init/insert/read port. It first writes the gap-penalty border. It then walks every inner cell in row-major order: request the diag/up/left neighbours, wait for the manager's read-complete toggle, compute the cell maximum and traceback direction, write the result back, and pulse `change_index`.

---
 rtl/score_fill_ctrl.sv | 169 ++++++++++++++++
 tb/tb_score_fill_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/score_fill_ctrl.sv
// Needleman-Wunsch fill sequencer: writes the gap border, then walks inner cells
// row-major, reading neighbours from the score RAM manager and writing max/dir back.
module score_fill_ctrl #(
    parameter int N        = 5,
    parameter int BitAddr  = $clog2(N + 1),
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         a_char,
    input  logic [1:0]         b_char,
    output logic [BitAddr:0]   a_idx,
    output logic [BitAddr:0]   b_idx,
    output logic               en_init,
    output logic [BitAddr:0]   addr_init,
    output logic [8:0]         data_init,
    output logic               en_ins,
    output logic               we,
    output logic [BitAddr:0]   i,
    output logic [BitAddr:0]   j,
    output logic [8:0]         max,
    output logic [1:0]         dir,
    output logic               en_read,
    input  logic [8:0]         diag,
    input  logic [8:0]         up,
    input  logic [8:0]         left,
    input  logic               signal,
    output logic               change_index,
    output logic               busy,
    output logic               done
);
    localparam int IW = BitAddr + 1;
    localparam logic [IW-1:0] KMAX = IW'(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [2:0] {IDLE, INIT, READ, CALC, WRITE, NEXT, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] k_q, k_d, i_q, i_d, j_q, j_d;
    logic [8:0]    max_q, max_d, diag_q, diag_d, up_q, up_d, left_q, left_d;
    logic [1:0]    dir_q, dir_d;
    logic          sig_q, edge_det;
    logic signed [9:0] d_sum, u_sum, l_sum;
    logic signed [8:0] d_sat, u_sat, l_sat;

    function automatic logic signed [8:0] sat9(input logic signed [9:0] v);
        if (v > 10'sd255)       return 9'h0FF;
        else if (v < -10'sd256) return 9'h100;
        else                    return v[8:0];
    endfunction

    assign edge_det = signal ^ sig_q;

    // Sums are widened one bit so saturation can see overflow in either direction.
    always_comb begin
        d_sum = {diag_q[8], diag_q} + ((a_char == b_char) ? 10'(MATCH) : 10'(MISMATCH));
        u_sum = {up_q[8], up_q} + 10'(GAP);
        l_sum = {left_q[8], left_q} + 10'(GAP);
        d_sat = sat9(d_sum);
        u_sat = sat9(u_sum);
        l_sat = sat9(l_sum);
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        max_d   = max_q;
        dir_d   = dir_q;
        diag_d  = diag_q;
        up_d    = up_q;
        left_d  = left_q;
        case (state_q)
            IDLE: if (start) begin
                k_d     = '0;
                i_d     = '0;
                j_d     = '0;
                state_d = INIT;
            end
            INIT: begin
                if (k_q == KMAX) state_d = READ;
                else             k_d = k_q + 1'b1;
            end
            READ: if (edge_det) begin
                diag_d  = diag;
                up_d    = up;
                left_d  = left;
                state_d = CALC;
            end
            CALC: begin
                // Ties resolve diag > up > left.
                if (d_sat >= u_sat && d_sat >= l_sat) begin
                    max_d = d_sat;
                    dir_d = 2'b00;
                end else if (u_sat >= l_sat) begin
                    max_d = u_sat;
                    dir_d = 2'b01;
                end else begin
                    max_d = l_sat;
                    dir_d = 2'b10;
                end
                state_d = WRITE;
            end
            WRITE: state_d = NEXT;
            NEXT: begin
                if (i_q == LAST && j_q == LAST) begin
                    state_d = DONE;
                end else begin
                    if (j_q == LAST) begin
                        j_d = '0;
                        i_d = i_q + 1'b1;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            max_q   <= '0;
            dir_q   <= '0;
            diag_q  <= '0;
            up_q    <= '0;
            left_q  <= '0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            max_q   <= max_d;
            dir_q   <= dir_d;
            diag_q  <= diag_d;
            up_q    <= up_d;
            left_q  <= left_d;
            sig_q   <= signal;
        end
    end

    assign en_init      = (state_q == INIT);
    assign addr_init    = en_init ? k_q : '0;
    assign data_init    = en_init ? 9'(int'(k_q) * GAP) : '0;
    assign en_ins       = (state_q == WRITE);
    assign we           = en_init | en_ins;
    assign en_read      = (state_q == READ);
    assign change_index = (state_q == NEXT);
    assign done         = (state_q == DONE);
    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign i            = i_q;
    assign j            = j_q;
    assign a_idx        = i_q;
    assign b_idx        = j_q;
    assign max          = max_q;
    assign dir          = dir_q;

endmodule

// File: tb/tb_score_fill_ctrl.sv
// Directed bench for score_fill_ctrl at N=2 with a small score RAM manager model.
module tb_score_fill_ctrl;
    localparam int N  = 2;
    localparam int BA = $clog2(N + 1);
    localparam int IW = BA + 1;

    logic          clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0]    a_char, b_char;
    logic [IW-1:0] a_idx, b_idx, addr_init, i, j;
    logic          en_init, en_ins, we, en_read, change_index, busy, done;
    logic [8:0]    data_init, max;
    logic [1:0]    dir;
    logic [8:0]    diag = '0, up = '0, left = '0;
    logic          signal = 1'b0;

    score_fill_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a_char(a_char), .b_char(b_char),
        .a_idx(a_idx), .b_idx(b_idx), .en_init(en_init), .addr_init(addr_init),
        .data_init(data_init), .en_ins(en_ins), .we(we), .i(i), .j(j), .max(max),
        .dir(dir), .en_read(en_read), .diag(diag), .up(up), .left(left),
        .signal(signal), .change_index(change_index), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [1:0] seq_a [0:7];
    logic [1:0] seq_b [0:7];
    assign a_char = seq_a[a_idx];
    assign b_char = seq_b[b_idx];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Manager model: score matrix, read latency of 3 en_read cycles, write log.
    logic [8:0] m [0:N][0:N];
    int   rcnt = 0, ci_ok = 0, done_cnt = 0;
    bit   spur_now = 0, spur_calc = 0, spur_pend = 0, ov_en = 0, prev_ins = 0;
    logic [8:0] ov_d = '0, ov_u = '0, ov_l = '0;
    logic [5:0] w_ij [$];
    logic [8:0] w_max [$];
    logic [1:0] w_dir [$];

    always @(negedge clk) begin
        if (spur_now || spur_pend) begin
            signal = ~signal;
            spur_now  = 0;
            spur_pend = 0;
        end
        if (en_init) begin
            m[0][addr_init] = data_init;
            m[addr_init][0] = data_init;
        end
        if (en_ins) begin
            m[i+1][j+1] = max;
            w_ij.push_back({i, j});
            w_max.push_back(max);
            w_dir.push_back(dir);
        end
        if (change_index && prev_ins) ci_ok++;
        if (done) done_cnt++;
        prev_ins = en_ins;
        if (en_read && rst) begin
            rcnt++;
            if (rcnt == 3) begin
                if (ov_en) begin
                    diag = ov_d; up = ov_u; left = ov_l;
                end else begin
                    diag = m[i][j]; up = m[i][j+1]; left = m[i+1][j];
                end
                signal    = ~signal;
                rcnt      = 0;
                spur_pend = spur_calc;
            end
        end else begin
            rcnt = 0;
        end
    end

    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done"}, done, 1'b1);
        @(negedge clk);
    endtask

    task automatic clear_log();
        w_ij.delete(); w_max.delete(); w_dir.delete();
        ci_ok = 0; done_cnt = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_ov(input string tag, input logic [1:0] ac, input logic [1:0] bc,
                          input logic [8:0] dg, input logic [8:0] u, input logic [8:0] l,
                          input logic [8:0] emax, input logic [1:0] edir);
        int cyc;
        seq_a[0] = ac; seq_b[0] = bc;
        ov_en = 1; ov_d = dg; ov_u = u; ov_l = l;
        clear_log();
        pulse_start();
        wait_done(tag, cyc);
        chk({tag, "_nw"}, w_max.size(), 4);
        chk({tag, "_max"}, w_max[0], emax);
        chk({tag, "_dir"}, w_dir[0], edir);
        ov_en = 0;
    endtask

    logic [5:0] exp_ij  [4] = '{6'o00, 6'o01, 6'o10, 6'o11};
    logic [8:0] exp_max [4] = '{9'h001, 9'h1FF, 9'h1FF, 9'h002};
    logic [1:0] exp_dir [4] = '{2'b00, 2'b10, 2'b01, 2'b00};

    task automatic chk_fill(input string tag);
        chk({tag, "_nw"}, w_max.size(), 4);
        for (int n = 0; n < 4 && n < w_max.size(); n++) begin
            chk($sformatf("%s_ij%0d", tag, n), w_ij[n], exp_ij[n]);
            chk($sformatf("%s_max%0d", tag, n), w_max[n], exp_max[n]);
            chk($sformatf("%s_dir%0d", tag, n), w_dir[n], exp_dir[n]);
        end
        chk({tag, "_ci"}, ci_ok, 4);
        chk({tag, "_donecnt"}, done_cnt, 1);
    endtask

    initial begin
        int cyc, total;
        for (int n = 0; n < 8; n++) begin seq_a[n] = 2'd0; seq_b[n] = 2'd0; end
        seq_a[0] = 2'd0; seq_a[1] = 2'd1;   // A = "AC"
        seq_b[0] = 2'd0; seq_b[1] = 2'd1;   // B = "AC"

        // Reset held with stimulus applied
        @(negedge clk);
        start = 1'b1; spur_now = 1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rst_outs", {en_init, en_ins, we, en_read, change_index, busy, done,
                         addr_init, data_init, i, j, max, dir, a_idx, b_idx}, '0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Border, plus a spurious toggle in INIT and a start during READ
        clear_log();
        spur_calc = 1;
        pulse_start();
        total = 1;
        chk("init0", {en_init, we, busy, addr_init, data_init}, {1'b1, 1'b1, 1'b1, 3'd0, 9'h000});
        spur_now = 1;
        @(negedge clk); total++;
        chk("init1", {en_init, we, addr_init, data_init}, {1'b1, 1'b1, 3'd1, 9'h1FE});
        @(negedge clk); total++;
        chk("init2", {en_init, we, addr_init, data_init}, {1'b1, 1'b1, 3'd2, 9'h1FC});
        @(negedge clk); total++;
        chk("read_after_init", {en_read, en_init}, 2'b10);
        pulse_start(); total++;
        wait_done("fill1", cyc);
        total += cyc;
        chk("fill1_latency", total, 28);
        chk_fill("fill1");
        spur_calc = 0;

        // Tie priority and saturation
        run_ov("tie_all",  2'd0, 2'd1, 9'h1FF, 9'h000, 9'h000, 9'h1FE, 2'b00);
        run_ov("tie_ul",   2'd0, 2'd1, 9'h1F6, 9'h000, 9'h000, 9'h1FE, 2'b01);
        run_ov("left_win", 2'd0, 2'd1, 9'h1F6, 9'h1FB, 9'h000, 9'h1FE, 2'b10);
        run_ov("sat_hi",   2'd0, 2'd0, 9'h0FF, 9'h000, 9'h000, 9'h0FF, 2'b00);
        run_ov("sat_lo",   2'd0, 2'd1, 9'h100, 9'h100, 9'h100, 9'h100, 2'b00);
        seq_a[0] = 2'd0; seq_b[0] = 2'd0;

        // Reset while reading the second cell
        pulse_start();
        cyc = 0;
        while (!(en_read && j == 3'd1) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("midread_reach", {en_read, j}, {1'b1, 3'd1});
        rst = 1'b0;
        #1;
        chk("midread_rst", {en_read, busy, i, j}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_log();
        pulse_start();
        chk("restart_init", {en_init, addr_init, data_init}, {1'b1, 3'd0, 9'h000});
        wait_done("fill2", cyc);
        chk_fill("fill2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
